// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the transmit and receive sides.
//   tx_state_t    : transmitter FSM state encoding
//   calc_baud_div : rounded clock-cycles-per-bit divider
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Round to the nearest integer divider rather than truncating.
    function automatic int calc_baud_div(input int clk, input int baud);
        return (clk + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. Counts 0..BAUD_DIV-1 while enabled and strobes
// o_bit_end on the last cycle of each bit period. Held at 0 when disabled,
// so every frame starts from a clean bit boundary.
// Ports:
//   r_clk     in  clock
//   r_rst     in  asynchronous active-low reset
//   i_en      in  count enable (frame in progress)
//   i_restart in  synchronous restart to 0
//   o_bit_end out high on the final cycle of the current bit
// ---------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 43
) (
    input  logic r_clk,
    input  logic r_rst,
    input  logic i_en,
    input  logic i_restart,
    output logic o_bit_end
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            r_cnt <= '0;
        end else if (i_restart || !i_en || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_bit_end = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
// UART serialiser: accepts one DATA_WIDTH word over valid/ready and sends
// start(0), data LSB first, optional parity, STOP_BITS stop bits(1).
// Line idles high. Every bit lasts BAUD_DIV r_clk cycles.
// Build option: define UART_TX_PARITY_EN to add a parity bit
// (sense set by PARITY_ODD: 0 = even, 1 = odd).
// Ports:
//   r_clk    in  clock
//   r_rst    in  asynchronous active-low reset
//   tx_data  in  word to send, sampled only on acceptance
//   tx_valid in  tx_data is valid
//   tx_ready out word can be accepted this cycle
//   tx_out   out serial line (flop output)
//   tx_busy  out frame in progress
//   tx_done  out pulse on the final cycle of the last stop bit
// ---------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int BAUD_RATE  = 1156000,
    parameter int CLOCK_FREQ = 50000000,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BAUD_DIV = calc_baud_div(CLOCK_FREQ, BAUD_RATE);
    localparam int BCW      = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    if (BAUD_DIV < 2) begin : g_bad_div
        $error("uart_transmitter: BAUD_DIV must be at least 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
        $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_par
        $error("uart_transmitter: PARITY_ODD must be 0 or 1");
    end

    tx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BCW-1:0]        r_bit_cnt;
    logic                  r_tx_out;
`ifdef UART_TX_PARITY_EN
    logic                  r_par;
`endif

    logic                  w_bit_end;
    logic                  w_last_stop;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_shift_nx;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .r_clk     (r_clk),
        .r_rst     (r_rst),
        .i_en      (r_state != IDLE),
        .i_restart (w_accept),
        .o_bit_end (w_bit_end)
    );

    // bit_cnt is reused as the stop-bit counter once data is out.
    assign w_last_stop = (r_state == STOP) && (r_bit_cnt == LAST_STOP);
    // Ready on the last stop cycle lets the next frame start with no gap.
    assign tx_ready    = (r_state == IDLE) || (w_last_stop && w_bit_end);
    assign tx_done     = w_last_stop && w_bit_end;
    assign tx_busy     = (r_state != IDLE);
    assign tx_out      = r_tx_out;
    assign w_accept    = tx_valid && tx_ready;
    assign w_shift_nx  = r_shift >> 1;

    // The line level for the next bit is set on the same edge as the state
    // change, so tx_out is a pure flop output.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx_out  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else if (w_accept) begin
            // Acceptance only happens in IDLE or on the final stop cycle.
            r_state   <= START;
            r_shift   <= tx_data;
            r_bit_cnt <= '0;
            r_tx_out  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par     <= (PARITY_ODD != 0);
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx_out <= 1'b1;
                end
                START: begin
                    if (w_bit_end) begin
                        r_state  <= DATA;
                        r_tx_out <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift <= w_shift_nx;
`ifdef UART_TX_PARITY_EN
                        r_par   <= r_par ^ r_shift[0];
`endif
                        if (r_bit_cnt == LAST_DATA) begin
                            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state   <= PARITY;
                            r_tx_out  <= r_par ^ r_shift[0];
`else
                            r_state   <= STOP;
                            r_tx_out  <= 1'b1;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                            r_tx_out  <= w_shift_nx[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_state  <= STOP;
                        r_tx_out <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == LAST_STOP) begin
                            r_state   <= IDLE;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                        end
                        r_tx_out <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
// Scoreboard bench: accepted words are queued with their acceptance cycle;
// a line monitor rebuilds each frame from tx_out and compares it to the
// frame the word should produce.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int CLK_HZ  = 50000000;
    localparam int BAUD    = 1156000;
    localparam int DIV     = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int PODD    = 0;
`ifdef UART_TX_PARITY_EN
    localparam int P       = 1;
`else
    localparam int P       = 0;
`endif
    localparam int NBITS   = 1 + 8 + P + 1;
    localparam int FRAME   = NBITS * DIV;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_out, tx_busy, tx_done;

    uart_transmitter #(
        .BAUD_RATE  (BAUD),
        .CLOCK_FREQ (CLK_HZ),
        .DATA_WIDTH (8),
        .STOP_BITS  (1),
        .PARITY_ODD (PODD)
    ) dut (
        .r_clk    (r_clk),
        .r_rst    (r_rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_out   (tx_out),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 r_clk = ~r_clk;

    int cyc = 0;
    always @(posedge r_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        int         acc;
    } exp_t;

    exp_t sb_q[$];

    // Line level of each bit slot of the frame carrying d.
    function automatic logic [15:0] frame_bits(input logic [7:0] d);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        if (P == 1) f[9] = (^d) ^ PODD[0];
        return f;
    endfunction

    // ---------------- monitor ----------------
    bit          mon_busy = 0;
    int          pos, bad, done_cnt = 0, done_cyc = 0;
    logic [15:0] fbits;
    logic [7:0]  rx;
    exp_t        cur;

    always @(negedge r_clk) begin
        if (!r_rst) begin
            mon_busy = 0;
        end else begin
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!mon_busy && tx_out === 1'b0) begin
                if (sb_q.size() == 0) begin
                    check(1'b0, "unexpected_frame", 1, 0);
                    cur.d   = 8'h00;
                    cur.acc = cyc;
                end else begin
                    cur = sb_q.pop_front();
                end
                check(cyc == cur.acc, "start_latency", cyc - cur.acc, 0);
                mon_busy = 1;
                pos      = 0;
                bad      = 0;
                rx       = 8'h00;
                fbits    = frame_bits(cur.d);
            end
            if (mon_busy) begin
                if (tx_out !== fbits[pos / DIV] || tx_busy !== 1'b1 ||
                    tx_done !== (pos == FRAME - 1)) bad++;
                if ((pos % DIV) == DIV / 2 && (pos / DIV) >= 1 && (pos / DIV) <= 8)
                    rx[(pos / DIV) - 1] = tx_out;
                if ((pos % DIV) == DIV - 1) begin
                    check(bad == 0, $sformatf("slot%0d_of_%02h_bad_samples", pos / DIV, cur.d), bad, 0);
                    bad = 0;
                end
                if (pos == FRAME - 1) begin
                    check(tx_done === 1'b1, "done_on_last_cycle", tx_done, 1);
                    check(rx == cur.d, "rx_word", rx, cur.d);
                    mon_busy = 0;
                end
                pos++;
            end else begin
                check(tx_busy === 1'b0 && tx_done === 1'b0 && tx_out === 1'b1,
                      "idle_flags", {tx_out, tx_busy, tx_done}, 3'b100);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] d, input bit hold, output int acc);
        int n;
        n   = 0;
        acc = -1;
        @(negedge r_clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 3000) begin
            @(negedge r_clk);
            n++;
        end
        if (!tx_ready) begin
            check(1'b0, "ready_timeout", 0, 1);
            tx_valid = 1'b0;
            return;
        end
        @(posedge r_clk);
        #1;
        acc = cyc;
        sb_q.push_back('{d, acc});
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || mon_busy) && n < 5000) begin
            @(negedge r_clk);
            n++;
        end
        check(n < 5000, "drain_timeout", n, 0);
        @(negedge r_clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge r_clk);
    endtask

    initial begin
        int a1, a2, d0;
        logic [7:0] w;
        bit hold;

        // Reset held with a valid word offered.
        r_rst    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        repeat (4) begin
            @(negedge r_clk);
            check(tx_out === 1'b1 && tx_busy === 1'b0 && tx_done === 1'b0,
                  "reset_outputs", {tx_out, tx_busy, tx_done}, 3'b100);
        end
        tx_valid = 1'b0;
        r_rst    = 1'b1;
        @(negedge r_clk);
        check(tx_ready === 1'b1, "ready_after_reset", tx_ready, 1);
        check(sb_q.size() == 0 && !mon_busy && done_cnt == 0, "nothing_accepted_in_reset", done_cnt, 0);

        // Single frame.
        d0 = done_cnt;
        send(8'hA5, 1'b0, a1);
        wait_idle();
        check(done_cnt - d0 == 1, "single_done_count", done_cnt - d0, 1);
        check(done_cyc - a1 + 1 == FRAME, "single_done_latency", done_cyc - a1 + 1, FRAME);

        // Back-to-back with valid held.
        d0 = done_cnt;
        send(8'h00, 1'b1, a1);
        send(8'hFF, 1'b0, a2);
        check(a2 - a1 == FRAME, "b2b_accept_spacing", a2 - a1, FRAME);
        wait_idle();
        check(done_cnt - d0 == 2, "b2b_done_count", done_cnt - d0, 2);
        check(done_cyc - a1 + 1 == 2 * FRAME, "b2b_total", done_cyc - a1 + 1, 2 * FRAME);

        // Busy protection: offer 3C during data bit 2, then change tx_data.
        send(8'h81, 1'b0, a1);
        wait_cyc(a1 + 3 * DIV + 10);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        check(tx_ready === 1'b0, "ready_low_while_busy", tx_ready, 0);
        @(negedge r_clk);
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        wait_idle();

        // Reset during data bit 4 (a zero bit of E7).
        send(8'hE7, 1'b0, a1);
        wait_cyc(a1 + 5 * DIV + 20);
        check(tx_out === 1'b0, "line_low_before_reset", tx_out, 0);
        #2;
        r_rst = 1'b0;
        #1;
        check(tx_out === 1'b1 && tx_busy === 1'b0, "async_reset_midframe", {tx_out, tx_busy}, 2'b10);
        repeat (3) @(negedge r_clk);
        r_rst = 1'b1;
        repeat (2) @(negedge r_clk);
        check(sb_q.size() == 0 && !mon_busy, "no_resume_after_reset", sb_q.size(), 0);
        d0 = done_cnt;
        send(8'h55, 1'b0, a1);
        wait_idle();
        check(done_cyc - a1 + 1 == FRAME && done_cnt - d0 == 1, "clean_frame_after_reset",
              done_cyc - a1 + 1, FRAME);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b0, a1);
        wait_idle();
        check(done_cyc - a1 + 1 == FRAME, "parity_frame_len", done_cyc - a1 + 1, FRAME);
`endif

        // Randomised words, gaps and back-to-back runs.
        for (int i = 0; i < 20; i++) begin
            w    = 8'($urandom);
            hold = ($urandom_range(0, 3) == 0) && (i != 19);
            send(w, hold, a1);
            if (!hold) repeat ($urandom_range(0, 40)) @(negedge r_clk);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
